column_drop_engine: RTL and testbench



---
 rtl/connect4_pkg.sv | 21 ++
 rtl/column_onehot_decoder.sv | 28 ++
 rtl/column_drop_engine.sv | 170 +++++++++++++++++
 tb/tb_column_drop_engine.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/connect4_pkg.sv
// Shared Connect-4 definitions: default board size, FSM states, cell
// addressing and player encoding.
package connect4_pkg;

    localparam int DEF_ROWS = 6;
    localparam int DEF_COLS = 7;

    localparam logic PLAYER1 = 1'b0;
    localparam logic PLAYER2 = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        FALL = 1'b1
    } state_t;

    // Boards are flattened row-major with row 0 at the bottom.
    function automatic int cell_index(input int row, input int col, input int cols);
        return row * cols + col;
    endfunction

endpackage

// File: rtl/column_onehot_decoder.sv
// Converts a one-hot column select into its binary index and flags
// inputs that are not exactly one-hot.
module column_onehot_decoder #(
    parameter  int COLS  = 7,
    localparam int COL_W = $clog2(COLS)
) (
    input  logic [COLS-1:0]  in_column,
    output logic [COL_W-1:0] index,
    output logic             onehot_ok
);

    int ones;

    // OR-ing the indices is exact for one-hot input; anything else is
    // rejected through onehot_ok so the merged index never gets used.
    always_comb begin
        index = '0;
        ones  = 0;
        for (int c = 0; c < COLS; c++) begin
            if (in_column[c]) begin
                index = index | COL_W'(c);
                ones++;
            end
        end
        onehot_ok = (ones == 1);
    end

endmodule

// File: rtl/column_drop_engine.sv
// Connect-4 move engine: validates a column request, animates the piece
// falling one row per step, then commits it to the occupancy/owner boards.
module column_drop_engine
    import connect4_pkg::*;
#(
    parameter  int ROWS        = DEF_ROWS,
    parameter  int COLS        = DEF_COLS,
    parameter  int STEP_CYCLES = 1,
    localparam int ROW_W       = $clog2(ROWS),
    localparam int COL_W       = $clog2(COLS),
    localparam int CELLS       = ROWS * COLS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [COLS-1:0]  in_column,
    input  logic             player,
    output logic [COL_W-1:0] column_decode,
    output logic [ROW_W-1:0] falling_row,
    output logic             falling,
    output logic             done,
    output logic [ROW_W-1:0] landed_row,
    output logic             invalid_column,
    output logic [CELLS-1:0] out_gameboard,
    output logic [CELLS-1:0] out_players_cells,
    output logic             board_full
);

    localparam int               CNT_W    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [ROW_W-1:0] TOP_ROW  = ROW_W'(ROWS - 1);

    state_t             state, state_n;
    logic [CNT_W-1:0]   step_cnt;
    logic [ROW_W-1:0]   target_q;
    logic               player_q;
    logic [COL_W-1:0]   col_idx;
    logic               onehot_ok;
    logic [COLS-1:0]    top_row;
    logic               col_full;
    logic [ROW_W-1:0]   search_row;
    logic [CELLS-1:0]   commit_mask;
    logic               accept, reject, commit, step_dec;

    column_onehot_decoder #(
        .COLS(COLS)
    ) u_decoder (
        .in_column(in_column),
        .index    (col_idx),
        .onehot_ok(onehot_ok)
    );

    always_comb begin
        top_row = '0;
        for (int c = 0; c < COLS; c++) begin
            top_row[c] = out_gameboard[cell_index(ROWS - 1, c, COLS)];
        end
    end

    assign board_full = &top_row;
    assign col_full   = |(in_column & top_row);
    assign req_ready  = (state == IDLE) && !clear;
    assign falling    = (state == FALL);

    // Lowest empty row of the selected column; scanning top-down lets the
    // last hit win. Only meaningful when the select is one-hot and not full.
    always_comb begin
        search_row = '0;
        for (int c = 0; c < COLS; c++) begin
            if (in_column[c]) begin
                for (int r = ROWS - 1; r >= 0; r--) begin
                    if (!out_gameboard[cell_index(r, c, COLS)]) begin
                        search_row = ROW_W'(r);
                    end
                end
            end
        end
    end

    assign commit_mask = CELLS'(1) << cell_index(int'(target_q), int'(column_decode), COLS);

    always_comb begin
        state_n  = state;
        accept   = 1'b0;
        reject   = 1'b0;
        commit   = 1'b0;
        step_dec = 1'b0;
        if (clear) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (onehot_ok && !col_full) begin
                            accept  = 1'b1;
                            state_n = FALL;
                        end else begin
                            reject = 1'b1;
                        end
                    end
                end
                FALL: begin
                    if (falling_row == target_q) begin
                        commit  = 1'b1;
                        state_n = IDLE;
                    end else if (step_cnt == CNT_LAST) begin
                        step_dec = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_gameboard     <= '0;
            out_players_cells <= '0;
            column_decode     <= '0;
            landed_row        <= '0;
            falling_row       <= '0;
            step_cnt          <= '0;
            target_q          <= '0;
            player_q          <= PLAYER1;
            done              <= 1'b0;
            invalid_column    <= 1'b0;
        end else begin
            done           <= commit;
            invalid_column <= reject;
            if (clear) begin
                out_gameboard     <= '0;
                out_players_cells <= '0;
                falling_row       <= '0;
                step_cnt          <= '0;
            end else begin
                if (accept) begin
                    player_q      <= player;
                    column_decode <= col_idx;
                    target_q      <= search_row;
                    falling_row   <= TOP_ROW;
                    step_cnt      <= '0;
                end
                if (commit) begin
                    out_gameboard     <= out_gameboard | commit_mask;
                    out_players_cells <= out_players_cells |
                                         ((player_q == PLAYER2) ? commit_mask : '0);
                    landed_row        <= target_q;
                end else if (state == FALL) begin
                    if (step_dec) begin
                        falling_row <= falling_row - 1'b1;
                        step_cnt    <= '0;
                    end else begin
                        step_cnt <= step_cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_column_drop_engine.sv
// Bench for column_drop_engine: instance 0 uses STEP_CYCLES=1, instance 1
// uses STEP_CYCLES=3; both are checked against a column-height board model.
module tb_column_drop_engine;

    localparam int R = 6;
    localparam int C = 7;
    localparam int N = R * C;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_s [2];
    logic         clr_s [2];
    logic         rv_s  [2];
    logic         pl_s  [2];
    logic [C-1:0] col_s [2];
    logic         rr    [2];
    logic [2:0]   cd    [2];
    logic [2:0]   fr    [2];
    logic         fa    [2];
    logic         dn    [2];
    logic [2:0]   lr    [2];
    logic         iv    [2];
    logic [N-1:0] gb    [2];
    logic [N-1:0] pc    [2];
    logic         bf    [2];

    column_drop_engine #(.ROWS(R), .COLS(C), .STEP_CYCLES(1)) dut0 (
        .clk(clk), .reset(rst_s[0]), .clear(clr_s[0]), .req_valid(rv_s[0]),
        .req_ready(rr[0]), .in_column(col_s[0]), .player(pl_s[0]),
        .column_decode(cd[0]), .falling_row(fr[0]), .falling(fa[0]), .done(dn[0]),
        .landed_row(lr[0]), .invalid_column(iv[0]), .out_gameboard(gb[0]),
        .out_players_cells(pc[0]), .board_full(bf[0])
    );

    column_drop_engine #(.ROWS(R), .COLS(C), .STEP_CYCLES(3)) dut1 (
        .clk(clk), .reset(rst_s[1]), .clear(clr_s[1]), .req_valid(rv_s[1]),
        .req_ready(rr[1]), .in_column(col_s[1]), .player(pl_s[1]),
        .column_decode(cd[1]), .falling_row(fr[1]), .falling(fa[1]), .done(dn[1]),
        .landed_row(lr[1]), .invalid_column(iv[1]), .out_gameboard(gb[1]),
        .out_players_cells(pc[1]), .board_full(bf[1])
    );

    // Reference model: pieces stacked per column, owner per cell.
    int           height [2][C];
    logic [N-1:0] mb     [2];
    logic [N-1:0] mo     [2];
    logic [2:0]   mcol   [2];
    logic [2:0]   mland  [2];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_full(input int s);
        for (int c = 0; c < C; c++) if (height[s][c] < R) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model_wipe(input int s, input bit full_reset);
        for (int c = 0; c < C; c++) height[s][c] = 0;
        mb[s] = '0;
        mo[s] = '0;
        if (full_reset) begin
            mcol[s]  = '0;
            mland[s] = '0;
        end
    endfunction

    function automatic int steps_of(input int s);
        return (s == 1) ? 3 : 1;
    endfunction

    // One request; checks the rejection or the full fall/commit timeline.
    task automatic drop(input int s, input logic [C-1:0] oh, input logic p);
        int  c, tgt, lat;
        bit  ok;
        ok = ($countones(oh) == 1);
        c  = 0;
        for (int i = 0; i < C; i++) if (oh[i]) c = i;
        if (ok && height[s][c] >= R) ok = 1'b0;
        @(negedge clk);
        rv_s[s] = 1'b1; col_s[s] = oh; pl_s[s] = p;
        @(negedge clk);
        rv_s[s] = 1'b0; col_s[s] = C'($urandom); pl_s[s] = 1'($urandom);
        #1;
        if (!ok) begin
            chk("invalid_pulse", iv[s], 1);
            chk("ready_after_reject", rr[s], 1);
            chk("no_fall_on_reject", fa[s], 0);
            chk("board_after_reject", gb[s], mb[s]);
            chk("owner_after_reject", pc[s], mo[s]);
            chk("decode_after_reject", cd[s], mcol[s]);
            chk("full_after_reject", bf[s], model_full(s));
            @(negedge clk);
            chk("invalid_one_cycle", iv[s], 0);
        end else begin
            tgt = height[s][c];
            lat = 2 + (R - 1 - tgt) * steps_of(s);
            for (int k = 1; k < lat; k++) begin
                chk("falling", fa[s], 1);
                chk("falling_row", fr[s], R - 1 - (k - 1) / steps_of(s));
                chk("no_early_done", dn[s], 0);
                @(negedge clk);
            end
            height[s][c] = tgt + 1;
            mb[s][tgt * C + c] = 1'b1;
            mo[s][tgt * C + c] = p;
            mcol[s]  = 3'(c);
            mland[s] = 3'(tgt);
            chk("done", dn[s], 1);
            chk("not_falling_at_done", fa[s], 0);
            chk("landed_row", lr[s], mland[s]);
            chk("column_decode", cd[s], mcol[s]);
            chk("gameboard", gb[s], mb[s]);
            chk("owner", pc[s], mo[s]);
            chk("ready_at_done", rr[s], 1);
            chk("board_full", bf[s], model_full(s));
        end
    endtask

    task automatic clear_board(input int s);
        @(negedge clk);
        clr_s[s] = 1'b1;
        #1;
        chk("ready_low_in_clear", rr[s], 0);
        @(negedge clk);
        clr_s[s] = 1'b0;
        #1;
        model_wipe(s, 1'b0);
        chk("clear_board", gb[s], 0);
        chk("clear_owner", pc[s], 0);
        chk("clear_ready", rr[s], 1);
    endtask

    // Starts a drop and kills it two cycles into the fall.
    task automatic abort_drop(input int s, input logic [C-1:0] oh, input bit use_reset);
        @(negedge clk);
        rv_s[s] = 1'b1; col_s[s] = oh; pl_s[s] = 1'b1;
        @(negedge clk);
        rv_s[s] = 1'b0;
        #1;
        chk("abort_started", fa[s], 1);
        @(negedge clk);
        if (use_reset) rst_s[s] = 1'b1;
        else           clr_s[s] = 1'b1;
        @(negedge clk);
        rst_s[s] = 1'b0;
        clr_s[s] = 1'b0;
        #1;
        model_wipe(s, use_reset);
        chk("abort_no_done", dn[s], 0);
        chk("abort_idle", fa[s], 0);
        chk("abort_board", gb[s], 0);
        chk("abort_owner", pc[s], 0);
        chk("abort_ready", rr[s], 1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("abort_never_done", dn[s], 0);
        end
    endtask

    initial begin
        int c;
        for (int s = 0; s < 2; s++) begin
            rst_s[s] = 1'b1; clr_s[s] = 1'b0; rv_s[s] = 1'b0;
            pl_s[s] = 1'b0; col_s[s] = '0;
            model_wipe(s, 1'b1);
        end
        repeat (3) @(negedge clk);
        rst_s[0] = 1'b0;
        rst_s[1] = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk("rst_ready", rr[s], 1);
            chk("rst_falling", fa[s], 0);
            chk("rst_falling_row", fr[s], 0);
            chk("rst_done", dn[s], 0);
            chk("rst_invalid", iv[s], 0);
            chk("rst_decode", cd[s], 0);
            chk("rst_landed", lr[s], 0);
            chk("rst_board", gb[s], 0);
            chk("rst_owner", pc[s], 0);
            chk("rst_full", bf[s], 0);
        end

        // Single P1 drop into the middle column of an empty board.
        drop(0, 7'b0001000, 1'b0);

        // Stack column 0 with alternating owners, then overflow it.
        clear_board(0);
        for (int i = 0; i < R; i++) drop(0, 7'b0000001, 1'(i % 2));
        drop(0, 7'b0000001, 1'b0);

        // Malformed selects.
        drop(0, 7'b0000000, 1'b0);
        drop(0, 7'b0000011, 1'b1);

        // Slow engine: each row held for three cycles.
        drop(1, 7'b0000100, 1'b1);
        drop(1, 7'b0000100, 1'b0);

        // Abort mid-fall by clear and by reset.
        abort_drop(0, 7'b0100000, 1'b0);
        abort_drop(1, 7'b1000000, 1'b1);

        // Random game until the board is full, with occasional junk selects.
        clear_board(0);
        while (!model_full(0)) begin
            if ($urandom_range(0, 7) == 0) begin
                drop(0, C'($urandom), 1'($urandom));
            end else begin
                do c = $urandom_range(0, C - 1); while (height[0][c] >= R);
                drop(0, C'(1) << c, 1'($urandom));
            end
        end
        for (int i = 0; i < 4; i++) drop(0, C'(1) << $urandom_range(0, C - 1), 1'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
